// File: rtl/reg_dump_scanner_pkg.sv
// Shared types and defaults for the register-dump scanner.
package reg_dump_scanner_pkg;

  localparam int DEF_SEL_W  = 5;
  localparam int DEF_DATA_W = 32;

  // Encodings are kept identical to the original scanner so dumps of the
  // state register read the same as before.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SEND   = 2'd2
  } scan_state_t;

endpackage

// File: rtl/reg_dump_scanner_if.sv
// Beat stream carrying {index, data, last} from the scanner to its sink.
interface reg_dump_scanner_if
  import reg_dump_scanner_pkg::*;
#(
  parameter int SEL_W  = DEF_SEL_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              out_valid;
  logic              out_ready;
  logic [SEL_W-1:0]  out_idx;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output out_valid,
    output out_idx,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/reg_dump_scanner.sv
// Reader for the CPU register-debug port: sweeps reg_sel over a latched
// index range, waits a settle time per index, and streams captured
// {index, data} beats out on a valid/ready interface.
module reg_dump_scanner
  import reg_dump_scanner_pkg::*;
#(
  parameter int SEL_W  = DEF_SEL_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [SEL_W-1:0]  first_sel,
  input  logic [SEL_W-1:0]  last_sel,
  output logic [SEL_W-1:0]  reg_sel,
  input  logic [DATA_W-1:0] reg_data,
  reg_dump_scanner_if.master out,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  scan_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic [SEL_W-1:0]  last_q;
  logic              valid_q;
  logic [SEL_W-1:0]  idx_q;
  logic [DATA_W-1:0] data_q;
  logic              last_beat_q;

  assign out.out_valid = valid_q;
  assign out.out_idx   = idx_q;
  assign out.out_data  = data_q;
  assign out.out_last  = last_beat_q;

  // Sweep FSM: all outputs registered; abort outranks the beat handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      last_q      <= '0;
      reg_sel     <= '0;
      valid_q     <= 1'b0;
      idx_q       <= '0;
      data_q      <= '0;
      last_beat_q <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            last_q  <= last_sel;
            reg_sel <= first_sel;
            cnt     <= CNT_LOAD;
            busy    <= 1'b1;
            state   <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (abort) begin
            valid_q     <= 1'b0;
            last_beat_q <= 1'b0;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end else if (cnt == CNT_ONE) begin
            cnt         <= '0;
            data_q      <= reg_data;
            idx_q       <= reg_sel;
            last_beat_q <= (reg_sel == last_q);
            valid_q     <= 1'b1;
            state       <= ST_SEND;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        ST_SEND: begin
          if (abort) begin
            valid_q     <= 1'b0;
            last_beat_q <= 1'b0;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end else if (valid_q && out.out_ready) begin
            valid_q <= 1'b0;
            if (last_beat_q) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              reg_sel <= reg_sel + 1'b1;
              cnt     <= CNT_LOAD;
              state   <= ST_SETTLE;
            end
          end
        end

        default: begin
          valid_q     <= 1'b0;
          last_beat_q <= 1'b0;
          busy        <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
